// File: rtl/move_scheduler_if.sv
// Command handshake between the move scheduler and the playfield update engine.
interface move_scheduler_if;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic       cmd_ack;

    modport master (output cmd_valid, output cmd_code, input cmd_ack);
    modport slave  (input cmd_valid, input cmd_code, output cmd_ack);
endinterface

// File: rtl/move_scheduler.sv
// Serializes key presses and level-dependent gravity ticks into one move command stream.
// Latency: key edge -> cmd_valid two cycles later; the engine holds off via cmd_ack, abandoned after ACK_TIMEOUT cycles.
module move_scheduler #(
    parameter int unsigned TICK_BASE   = 25_000_000,
    parameter int unsigned LEVEL_STEP  = 2_000_000,
    parameter int unsigned TICK_MIN    = 2_500_000,
    parameter int unsigned FAST_SHIFT  = 3,
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_sig,
    input  logic             over_sig,
    input  logic             key_left_n,
    input  logic             key_right_n,
    input  logic             key_rotate_n,
    input  logic             fast_drop,
    input  logic             level_up,
    move_scheduler_if.master cmd,
    output logic [3:0]       level,
    output logic             tick,
    output logic             cmd_timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    localparam logic [1:0] CODE_LEFT   = 2'd0;
    localparam logic [1:0] CODE_RIGHT  = 2'd1;
    localparam logic [1:0] CODE_ROTATE = 2'd2;
    localparam logic [1:0] CODE_DROP   = 2'd3;

    localparam int unsigned     TO_W    = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    localparam logic [28:0] BASE29 = 29'(TICK_BASE);
    localparam logic [28:0] STEP29 = 29'(LEVEL_STEP);
    localparam logic [28:0] MIN29  = 29'(TICK_MIN);

    logic            run;
    logic [1:0]      state;
    logic [2:0]      key_prev;
    logic            start_prev;
    logic [3:0]      pend;
    logic [3:0]      pend_nxt;
    logic [3:0]      set_vec;
    logic [3:0]      clr_vec;
    logic [24:0]     grav_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            to_last;
    logic            grav_hit;
    logic [1:0]      pick_code;

    logic [28:0] step_prod;
    logic [28:0] base_p;
    logic [28:0] eff_p;

    assign run     = start_sig & ~over_sig;
    assign to_last = (to_cnt == TO_LAST);

    // Period from the current level; the subtraction is clamped so deep levels settle at the floor.
    assign step_prod = {25'd0, level} * STEP29;

    always_comb begin
        base_p = BASE29 - step_prod;
        if (step_prod >= BASE29 || (BASE29 - step_prod) < MIN29) begin
            base_p = MIN29;
        end
        eff_p = fast_drop ? (base_p >> FAST_SHIFT) : base_p;
        if (eff_p == 29'd0) begin
            eff_p = 29'd1;
        end
    end

    // >= rather than == so a period that shrinks mid-count fires at once.
    assign grav_hit = (state != ST_IDLE) && ({4'd0, grav_cnt} >= (eff_p - 29'd1));

    always_comb begin
        if (pend[CODE_DROP]) begin
            pick_code = CODE_DROP;
        end else if (pend[CODE_ROTATE]) begin
            pick_code = CODE_ROTATE;
        end else if (pend[CODE_LEFT]) begin
            pick_code = CODE_LEFT;
        end else begin
            pick_code = CODE_RIGHT;
        end
    end

    // A fresh request in the cycle its code is served survives the clear.
    always_comb begin
        set_vec              = '0;
        set_vec[CODE_LEFT]   = key_prev[0] & ~key_left_n;
        set_vec[CODE_RIGHT]  = key_prev[1] & ~key_right_n;
        set_vec[CODE_ROTATE] = key_prev[2] & ~key_rotate_n;
        set_vec[CODE_DROP]   = grav_hit;
        clr_vec              = '0;
        if (state == ST_ISSUE && (cmd.cmd_ack || to_last)) begin
            clr_vec[cmd.cmd_code] = 1'b1;
        end
        pend_nxt = (pend & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            key_prev      <= 3'b111;
            start_prev    <= 1'b0;
            pend          <= '0;
            grav_cnt      <= '0;
            to_cnt        <= '0;
            level         <= 4'd0;
            tick          <= 1'b0;
            cmd_timeout   <= 1'b0;
            cmd.cmd_valid <= 1'b0;
            cmd.cmd_code  <= 2'd0;
        end else begin
            key_prev    <= {key_rotate_n, key_right_n, key_left_n};
            start_prev  <= start_sig;
            tick        <= 1'b0;
            cmd_timeout <= 1'b0;

            if (start_sig && !start_prev) begin
                level <= 4'd0;
            end else if (run && level_up && level != 4'd15) begin
                level <= level + 4'd1;
            end

            if (!run) begin
                state         <= ST_IDLE;
                pend          <= '0;
                grav_cnt      <= '0;
                to_cnt        <= '0;
                cmd.cmd_valid <= 1'b0;
            end else if (state == ST_IDLE) begin
                state    <= ST_ARB;
                pend     <= '0;
                grav_cnt <= '0;
            end else begin
                pend <= pend_nxt;
                if (grav_hit) begin
                    grav_cnt <= '0;
                    tick     <= 1'b1;
                end else begin
                    grav_cnt <= grav_cnt + 25'd1;
                end

                case (state)
                    ST_ARB: begin
                        if (|pend) begin
                            cmd.cmd_code  <= pick_code;
                            cmd.cmd_valid <= 1'b1;
                            to_cnt        <= '0;
                            state         <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        if (cmd.cmd_ack) begin
                            cmd.cmd_valid <= 1'b0;
                            state         <= ST_ARB;
                        end else if (to_last) begin
                            cmd.cmd_valid <= 1'b0;
                            cmd_timeout   <= 1'b1;
                            state         <= ST_ARB;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/move_scheduler.md
# move_scheduler

Command scheduler between the debounced button/speed inputs and the playfield update engine of the tetris game. It turns left/right/rotate button presses and an internally generated, level-dependent gravity tick into a single serialized stream of move commands. Commands are issued one at a time over a valid/ack handshake, so the playfield datapath never sees two concurrent updates. It is active only while the game is running: `start_sig` high and `over_sig` low.

## Interface
- TICK_BASE, 25_000_000: gravity period in clk cycles at level 0; must be < 2^25.
- LEVEL_STEP, 2_000_000: period reduction per level.
- TICK_MIN, 2_500_000: floor on the gravity period.
- FAST_SHIFT, 3: right shift applied to the period while fast drop is held.
- ACK_TIMEOUT, 1024: cycles to wait for `cmd_ack` before abandoning a command.

Ports:
- clk  in  1  pixel/system clock from the clock divider.
- rst_n  in  1  asynchronous, active-low reset.
- start_sig  in  1  game-running level from the game state automaton.
- over_sig  in  1  game-over level.
- key_left_n, key_right_n, key_rotate_n  in  1 each  debounced buttons, active low (level).
- fast_drop  in  1  debounced vertical-speed level, active high.
- level_up  in  1  one-cycle pulse from scoring.
- cmd_ack  in  1  engine accepted the current command.
- cmd_valid  out  1  command present.
- cmd_code  out  2  command code: 0 LEFT, 1 RIGHT, 2 ROTATE, 3 DROP.
- level  out  4  current level (0..15).
- tick  out  1  one-cycle gravity tick pulse.
- cmd_timeout  out  1  one-cycle pulse when a command is abandoned.

## Operation
- `run = start_sig & ~over_sig`.
- Edge detection: a falling edge on each `key_*_n` (previous sample 1, current sample 0) sets that key's sticky pending flag. The previous-sample registers reset to 1.
- Four pending flags, one each for LEFT, RIGHT, ROTATE, DROP.
  - A new edge while the flag is already set coalesces into the existing request; nothing is counted.
  - When the command is served and a new edge of the same code arrives in the same cycle, the flag stays set.
- Gravity counter, 25 bits, counts only while `run`.
  - Period P = max(TICK_BASE − level·LEVEL_STEP, TICK_MIN), computed in 29-bit unsigned arithmetic.
  - While `fast_drop` is high, P is replaced by P >> FAST_SHIFT, with a minimum of 1.
  - When the counter reaches ≥ P−1 it clears, pulses `tick`, and sets DROP pending. Using ≥ makes a mid-count period decrease take effect immediately.
- Level:
  - Increments on `level_up` and saturates at 15.
  - Clears to 0 on the rising edge of `start_sig` (new game).
  - `level_up` is ignored when not `run`.
- FSM states and transitions:
  - IDLE:
    - `cmd_valid` is 0; flags and the gravity counter are held at 0.
    - Goes to ARB when `run`.
  - ARB:
    - If any flag is set, picks by fixed priority DROP > ROTATE > LEFT > RIGHT.
    - Registers `cmd_code`, sets `cmd_valid`, clears the timeout counter, and goes to ISSUE.
    - Otherwise stays in ARB.
  - ISSUE:
    - `cmd_valid` and `cmd_code` are held stable.
    - On `cmd_ack`: clears the served flag, drops `cmd_valid`, and goes to ARB.
    - If the timeout counter reaches ACK_TIMEOUT−1 without an ack: clears the flag, drops `cmd_valid`, pulses `cmd_timeout`, and goes to ARB.
  - Any state, when `run` is 0: on the next cycle, goes to IDLE with `cmd_valid` 0 and all flags and counters cleared. Dropping an outstanding command here is the only legal withdrawal of `cmd_valid` without an ack or timeout.
- `cmd_ack` outside ISSUE is ignored.

## Timing
- Reset values:
  - `cmd_valid` 0, `cmd_code` 0, `level` 0, `tick` 0, `cmd_timeout` 0.
  - FSM in IDLE; key sample registers 1.
- Key edge sampled at cycle n: flag visible at n+1; if the FSM is in ARB, `cmd_valid` is high at n+2.
- Ack sampled at cycle m: `cmd_valid` low at m+1; the next command has `cmd_valid` high at m+2 at the earliest.
  - One-cycle low gap between commands is guaranteed.
- `run` rising at cycle r: FSM in ARB at r+1; gravity counter starts counting at r+1.
- Timeout: `cmd_valid` high for exactly ACK_TIMEOUT cycles, then low, with `cmd_timeout` high in the same cycle `cmd_valid` falls.
- All outputs registered; no combinational input-to-output path.

## Test plan
- Reset, then `start_sig`=1, press left (key_left_n 1→0 at cycle 10) → `cmd_valid`=1 with `cmd_code`=0 at cycle 12; ack at 15 → `cmd_valid`=0 at 16.
- Left, rotate, and right edges in the same cycle, engine acks each cycle it sees `cmd_valid` → codes issued in order 2, 0, 1, each separated by one idle cycle.
- TICK_BASE=100, TICK_MIN=20, LEVEL_STEP=10, level 0 → `tick` every 100 cycles with code 3 issued. After 3 `level_up` pulses the period is 70; after 20 pulses `level`=15 and the period is 20. `fast_drop`=1 → period 100>>3 = 12.
- Hold `cmd_ack`=0 with ACK_TIMEOUT=16 → `cmd_valid` high for 16 cycles, `cmd_timeout` pulses once, and the next pending command follows 1 cycle later.
- Assert `over_sig` while in ISSUE → `cmd_valid`=0 the next cycle, no further commands, `tick` silent. Then deassert `over_sig`, toggle `start_sig` → `level`=0 and the counter restarts from 0.
- Press left 5 times while a DROP is outstanding and unacked → exactly one LEFT is issued after the DROP is acked.
